// File: rtl/pll_supervisor.sv
// PLL supervisor: sequences PLL areset, waits for lock, then qualifies the monitored clock over
// repeated measurement windows before releasing the downstream clock enable and reset.
// Optional sticky error flags are built when PLL_SUP_STICKY_ERR_EN is defined.
module pll_supervisor #(
  parameter int unsigned RST_CYC   = 16,
  parameter int unsigned LOCK_TMO  = 1000,
  parameter int unsigned WIN_CYC   = 64,
  parameter int unsigned EXP_CNT   = 24,
  parameter int unsigned TOL       = 2,
  parameter int unsigned GOOD_WIN  = 4,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       locked,
  input  logic       mon_tog,
  output logic       pll_areset,
  output logic       clk_en,
  output logic       rst_out_n,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] meas_cnt,
  output logic [2:0] err_flags
);

  localparam int unsigned CYC_MAX = (LOCK_TMO > RST_CYC) ? LOCK_TMO : RST_CYC;
  localparam int unsigned CW      = $clog2(CYC_MAX + 1);
  localparam int unsigned WW      = $clog2(WIN_CYC + 1);
  localparam int unsigned GW      = $clog2(GOOD_WIN + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TMO - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CYC - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_WIN - 1);
  localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);
  localparam int            LO_BOUND  = int'(EXP_CNT) - int'(TOL);
  localparam int            HI_BOUND  = int'(EXP_CNT) + int'(TOL);

  typedef enum logic [2:0] {
    IDLE, PLL_RST, WAIT_LOCK, MEASURE, RUN, RETRY, FAIL
  } state_t;

  state_t state, state_next;

  logic [1:0]    lock_sy;
  logic [2:0]    tog_sy;
  logic [2:0]    start_sy;
  logic          lock_ok, tog_edge, start_edge;

  logic [CW-1:0] cyc_cnt;
  logic [WW-1:0] win_cnt;
  logic [7:0]    edge_cnt;
  logic [GW-1:0] good_cnt;
  logic [1:0]    retry_next;
  logic          meas_act, win_end, below, above, in_range;
  logic          areset_d, clk_en_d, rst_out_d, fail_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_sy  <= '0;
      tog_sy   <= '0;
      start_sy <= '0;
    end else begin
      lock_sy  <= {lock_sy[0], locked};
      tog_sy   <= {tog_sy[1:0], mon_tog};
      start_sy <= {start_sy[1:0], start};
    end
  end

  assign lock_ok    = lock_sy[1];
  assign tog_edge   = tog_sy[1] ^ tog_sy[2];
  assign start_edge = start_sy[1] & ~start_sy[2];

  assign meas_act = (state == MEASURE) || (state == RUN);
  assign win_end  = meas_act && (win_cnt == WIN_LAST);
  assign below    = int'(edge_cnt) < LO_BOUND;
  assign above    = int'(edge_cnt) > HI_BOUND;
  assign in_range = !below && !above;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    retry_next = retry_cnt;
    unique case (state)
      IDLE:      ;
      PLL_RST:   if (cyc_cnt == RST_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_ok)                    state_next = MEASURE;
        else if (cyc_cnt == TMO_LAST)   state_next = RETRY;
      end
      MEASURE: begin
        if (!lock_ok) state_next = RETRY;
        else if (win_end && in_range && good_cnt == GOOD_LAST) state_next = RUN;
      end
      // lock loss and a bad window in the same cycle still yield a single retry
      RUN:       if (!lock_ok || (win_end && !in_range)) state_next = RETRY;
      RETRY: begin
        if (retry_cnt == RETRY_LIM) state_next = FAIL;
        else begin
          retry_next = retry_cnt + 2'd1;
          state_next = PLL_RST;
        end
      end
      FAIL:      ;
      default:   state_next = IDLE;
    endcase
    if (start_edge) begin
      state_next = PLL_RST;
      retry_next = '0;
    end

    areset_d  = (state_next == IDLE) || (state_next == PLL_RST) || (state_next == FAIL);
    clk_en_d  = (state_next == RUN);
    rst_out_d = (state_next == RUN) && (state == RUN);
    fail_d    = (state_next == FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt  <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      good_cnt <= '0;
      meas_cnt <= '0;
    end else begin
      if (state_next != state || start_edge)              cyc_cnt <= '0;
      else if (state == PLL_RST || state == WAIT_LOCK)    cyc_cnt <= cyc_cnt + CW'(1);

      if (state_next == MEASURE && state != MEASURE) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        good_cnt <= '0;
      end else if (meas_act) begin
        if (win_end) begin
          // an edge landing on the closing cycle belongs to the next window
          win_cnt  <= '0;
          meas_cnt <= edge_cnt;
          edge_cnt <= {7'd0, tog_edge};
          if (state == MEASURE) good_cnt <= in_range ? good_cnt + GW'(1) : '0;
        end else begin
          win_cnt <= win_cnt + WW'(1);
          if (tog_edge && edge_cnt != 8'hFF) edge_cnt <= edge_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pll_areset <= 1'b1;
      clk_en     <= 1'b0;
      rst_out_n  <= 1'b0;
      fail       <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      pll_areset <= areset_d;
      clk_en     <= clk_en_d;
      rst_out_n  <= rst_out_d;
      fail       <= fail_d;
      retry_cnt  <= retry_next;
    end
  end

`ifdef PLL_SUP_STICKY_ERR_EN
  logic [2:0] err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else if (start_edge) err_q <= '0;
    else if (meas_act) begin
      if (!lock_ok)         err_q[0] <= 1'b1;
      if (win_end && below) err_q[1] <= 1'b1;
      if (win_end && above) err_q[2] <= 1'b1;
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = '0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed plus randomized bench for pll_supervisor; expected values come from a window-level
// model (list of per-window edge counts -> good streak, run/retry/fail, flags).
module tb_pll_supervisor;

  localparam int LO = 24 - 2;
  localparam int HI = 24 + 2;

  logic       clk = 1'b0;
  logic       reset, start, locked, mon_tog;
  logic       pll_areset, clk_en, rst_out_n, fail;
  logic [1:0] retry_cnt;
  logic [7:0] meas_cnt;
  logic [2:0] err_flags;

  int total = 0;
  int bad   = 0;

  // window-level reference model state
  bit       m_run, m_fail;
  int       m_good, m_retry, m_meas;
  bit [2:0] m_flags;

  pll_supervisor #(
    .RST_CYC(16), .LOCK_TMO(1000), .WIN_CYC(64), .EXP_CNT(24),
    .TOL(2), .GOOD_WIN(4), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .locked(locked), .mon_tog(mon_tog),
    .pll_areset(pll_areset), .clk_en(clk_en), .rst_out_n(rst_out_n), .fail(fail),
    .retry_cnt(retry_cnt), .meas_cnt(meas_cnt), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_flags();
`ifdef PLL_SUP_STICKY_ERR_EN
    return m_flags;
`else
    return 3'b000;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_areset"}, pll_areset, 1);
    check({tag, "_clk_en"}, clk_en, 0);
    check({tag, "_rst_out_n"}, rst_out_n, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_meas"}, meas_cnt, 0);
    check({tag, "_flags"}, err_flags, 0);
  endtask

  // Start pulse from anywhere: abort values three edges later, then a 16-cycle areset.
  task automatic start_and_fall();
    int n;
    start = 1'b1; step();
    start = 1'b0; step(); step();
    m_retry = 0; m_fail = 0; m_flags = '0; m_run = 0; m_good = 0;
    check("abort_areset", pll_areset, 1);
    check("abort_clk_en", clk_en, 0);
    check("abort_rst_out_n", rst_out_n, 0);
    check("abort_fail", fail, 0);
    check("abort_retry", retry_cnt, 0);
    check("abort_flags", err_flags, 0);
    n = 0;
    while (pll_areset === 1'b1 && n < 40) begin step(); n++; end
    check("rst_cyc_len", n, 16);
  endtask

  task automatic resync_after_retry();
    int n;
    n = 0;
    while (pll_areset === 1'b1 && n < 40) begin step(); n++; end
    check("retry_areset_len", n, 16);
    m_run = 0; m_good = 0;
  endtask

  // Position k is "just after edge base+k" where base+2 is the first MEASURE edge of window w.
  // A toggle driven at k is counted in win_cnt slot k of the same window.
  task automatic run_windows(input int cnt[$], input int k0, output bit exited);
    int  nw, n;
    bit  prev_run, in_r;
    nw = cnt.size();
    exited = 0;
    for (int w = 0; w <= nw; w++) begin
      n = (w < nw) ? cnt[w] : 0;
      for (int k = (w == 0) ? k0 : 0; k < 64; k++) begin
        if (k >= 4 && k < 4 + 2 * n && (k % 2) == 0) mon_tog = ~mon_tog;
        if (w > 0 && k == 1) check("clk_en_pre", clk_en, m_run);
        if (w > 0 && k == 2) begin
          prev_run = m_run;
          m_meas = cnt[w-1];
          in_r = (m_meas >= LO) && (m_meas <= HI);
          if (m_meas < LO) m_flags[1] = 1'b1;
          if (m_meas > HI) m_flags[2] = 1'b1;
          if (m_run) begin
            if (!in_r) begin
              m_run = 0;
              exited = 1;
              if (m_retry == 3) m_fail = 1;
              else m_retry++;
            end
          end else if (in_r) begin
            m_good++;
            if (m_good == 4) m_run = 1;
          end else m_good = 0;
          check("meas_cnt", meas_cnt, m_meas);
          check("clk_en_post", clk_en, m_run);
          check("rst_out_n_post", rst_out_n, prev_run && m_run);
          check("err_flags", err_flags, exp_flags());
          if (exited) begin
            step();
            check("exit_retry", retry_cnt, m_retry);
            check("exit_fail", fail, m_fail);
            check("exit_areset", pll_areset, 1);
            return;
          end
        end
        if (w > 0 && k == 3) begin
          check("rst_out_n_late", rst_out_n, m_run);
          check("retry_hold", retry_cnt, m_retry);
        end
        if (w == nw && k == 3) return;
        step();
      end
    end
  endtask

  initial begin
    int  q[$];
    int  n;
    bit  ex;

    reset = 1'b0; start = 1'b0; locked = 1'b0; mon_tog = 1'b0;
    m_run = 0; m_fail = 0; m_good = 0; m_retry = 0; m_meas = 0; m_flags = '0;
    step(); step();
    check_reset_vals("por");
    reset = 1'b1;
    repeat (5) step();
    check("idle_areset", pll_areset, 1);

    // nominal bring-up: lock 100 cycles after areset release, 24 edges per window
    start_and_fall();
    repeat (100) step();
    check("wait_lock_areset", pll_areset, 0);
    locked = 1'b1;
    step();
    q = {24, 24, 24, 24, 24};
    run_windows(q, 0, ex);

    // 22 and 26 accepted, 27 resets the streak; 27 again in RUN forces a retry
    start_and_fall();
    q = {22, 26, 27, 24, 24, 24, 24, 27};
    run_windows(q, 1, ex);
    check("bw_exited", ex, 1);
    resync_after_retry();

    // randomized window counts, continuing the retry budget
    for (int s = 0; s < 3; s++) begin
      q.delete();
      for (int i = 0; i < 12; i++)
        q.push_back(($urandom_range(0, 3) != 0) ? int'($urandom_range(LO, HI))
                                                : int'($urandom_range(14, 30)));
      run_windows(q, 1, ex);
      if (!ex || m_fail) break;
      resync_after_retry();
    end

    // lock drop for 3 cycles in RUN, then recovery
    start_and_fall();
    q = {24, 24, 24, 24};
    run_windows(q, 1, ex);
    repeat (5) step();
    locked = 1'b0;
    step(); step();
    check("lock_drop_pre", clk_en, 1);
    step();
    m_flags[0] = 1'b1;
    check("lock_drop_clk_en", clk_en, 0);
    check("lock_drop_rst_out_n", rst_out_n, 0);
    check("lock_drop_flags", err_flags, exp_flags());
    locked = 1'b1;
    step();
    m_retry = 1;
    check("lock_drop_retry", retry_cnt, 1);
    resync_after_retry();
    q = {24, 24, 24, 24};
    run_windows(q, 1, ex);
    check("relock_run", clk_en, 1);

    // lock never arrives: four timeouts then FAIL
    locked = 1'b0;
    start_and_fall();
    for (int a = 1; a <= 4; a++) begin
      n = 0;
      while (pll_areset === 1'b0 && n < 1100) begin step(); n++; end
      check("tmo_len", n, 1001);
      check("tmo_retry", retry_cnt, (a < 4) ? a : 3);
      check("tmo_fail", fail, (a == 4) ? 1 : 0);
      if (a < 4) begin
        n = 0;
        while (pll_areset === 1'b1 && n < 40) begin step(); n++; end
        check("tmo_areset_len", n, 16);
      end
    end
    repeat (20) step();
    check("fail_hold", fail, 1);
    check("fail_areset", pll_areset, 1);
    check("fail_clk_en", clk_en, 0);

    // restart from FAIL, then asynchronous reset mid-MEASURE
    locked = 1'b1;
    start_and_fall();
    q = {24};
    run_windows(q, 1, ex);
    for (int i = 0; i < 6; i++) begin mon_tog = ~mon_tog; step(); end
    check("pre_reset_areset", pll_areset, 0);
    #3 reset = 1'b0;
    #1 check_reset_vals("async");
    step(); step();
    reset = 1'b1;
    m_run = 0; m_good = 0; m_retry = 0; m_meas = 0; m_flags = '0;
    for (int i = 0; i < 40; i++) begin
      if ((i % 2) == 0) mon_tog = ~mon_tog;
      step();
    end
    check("post_reset_areset", pll_areset, 1);
    check("post_reset_meas", meas_cnt, 0);
    check("post_reset_clk_en", clk_en, 0);

    // stuck monitored clock: zero counts, freq_low, never released
    start_and_fall();
    q = {0, 0, 0, 0, 0};
    run_windows(q, 1, ex);
    check("stuck_no_release", clk_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Supervises the PLL that feeds the gated-clock and reset manager. Drives the PLL areset and monitors `locked` and the frequency of a monitored clock.
- The monitored clock is seen only through a toggle signal generated in its own domain.
- Releases the downstream clock-gate enable and reset only after repeated good measurements. Re-initialises the PLL on lock loss or frequency error.
- Runs entirely on the 50 MHz board clock and sits beside the clock manager at the top level.

Parameters:
- RST_CYC, 16: cycles `pll_areset` is held high per attempt.
- LOCK_TMO, 1000: maximum cycles to wait for `locked` after areset is released.
- WIN_CYC, 64: measurement window length in clk cycles.
- EXP_CNT, 24: expected `mon_tog` edges (rise plus fall) per window.
- TOL, 2: allowed ± deviation from EXP_CNT.
- GOOD_WIN, 4: consecutive in-range windows required before release.
- MAX_RETRY, 3: PLL re-init attempts before declaring failure.

Ports:
- clk, input, 1: 50 MHz board clock; the only clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: level; rising edge (detected in clk) starts or restarts supervision.
- locked, input, 1: PLL lock, asynchronous to clk.
- mon_tog, input, 1: toggle from the monitored clock domain (monitored clock / 16), asynchronous.
- pll_areset, output, 1: PLL asynchronous reset request.
- clk_en, output, 1: enable for downstream clock gating.
- rst_out_n, output, 1: active-low reset for downstream logic.
- fail, output, 1: retries exhausted.
- retry_cnt, output, 2: attempts used.
- meas_cnt, output, 8: edge count of the last completed window.
- err_flags, output, 3: sticky errors {freq_high, freq_low, lock_lost}.

Behaviour:
- Reset values:
  - pll_areset = 1, clk_en = 0, rst_out_n = 0, fail = 0.
  - retry_cnt = 0, meas_cnt = 0, err_flags = 0.
  - State = IDLE.
- Synchronisers:
  - `locked` and `mon_tog` each pass through 2 flops, then a third flop for edge detect.
  - Edge = sync2 XOR sync3.
  - `start` is synchronised the same way; rising edge only.
- IDLE: pll_areset = 1. On start edge → PLL_RST, retry_cnt = 0.
- PLL_RST: pll_areset = 1 for exactly RST_CYC cycles → WAIT_LOCK.
- WAIT_LOCK: pll_areset = 0.
  - Synchronised locked = 1 → MEASURE, clearing window counter, edge counter and good counter.
  - LOCK_TMO cycles without lock → RETRY.
- MEASURE / RUN window rules:
  - Window counter counts 0..WIN_CYC-1. The edge counter saturates at 255.
  - At window end, meas_cnt ← edge count and the edge counter restarts in the same cycle; an edge on that cycle counts toward the new window.
  - In range: EXP_CNT-TOL ≤ count ≤ EXP_CNT+TOL, inclusive.
- MEASURE:
  - In-range window: good counter +1. On reaching GOOD_WIN → RUN.
  - Out-of-range window: good counter = 0; stay in MEASURE.
  - Synchronised locked = 0 → RETRY.
- RUN:
  - clk_en = 1 on entry; rst_out_n = 1 one cycle later, so the clock runs before reset release.
  - Measurement continues. Lock loss or one out-of-range window: clk_en = 0 and rst_out_n = 0 in the same cycle → RETRY.
  - retry_cnt is not cleared by RUN.
- RETRY: if retry_cnt == MAX_RETRY → FAIL; else retry_cnt +1 → PLL_RST. Takes 1 cycle.
- FAIL: fail = 1, pll_areset = 1, clk_en = 0, rst_out_n = 0. Only a start edge (→ PLL_RST, retry_cnt = 0, fail = 0) or reset exits.
- Start edge in any state other than IDLE/FAIL: abort to PLL_RST, clk_en = 0, rst_out_n = 0, retry_cnt = 0.
- Simultaneous lock loss and window-end out-of-range: one retry only.
- Reset mid-operation forces all reset values immediately (asynchronous). Outputs are registered.

Optional Feature:
- PLL_SUP_STICKY_ERR_EN defined:
  - err_flags bits set on each event (lock loss in MEASURE/RUN, count < low bound, count > high bound).
  - Bits hold until a start edge or reset.
- Not defined: err_flags tied to 0 and no flag registers are built.

Test Plan:
- Start pulse, locked rises 100 cycles after areset release, mon_tog with 24 edges/window → pll_areset high for 16 cycles, then clk_en = 1 after 4 windows (256 cycles), rst_out_n one cycle later, meas_cnt = 24.
- Window counts 22, 26, 27 → first two accepted, 27 resets the good counter; in RUN, 27 → clk_en/rst_out_n drop at once, retry_cnt = 1, err_flags = 3'b100 with macro.
- locked never asserts → 4 areset/timeout cycles of 16 + 1000, then fail = 1, retry_cnt = 3; a new start pulse → fail = 0, retry_cnt = 0, PLL_RST.
- locked drops for 3 cycles in RUN → clk_en = 0 within the 2-flop sync latency + 1, err_flags[0] = 1, re-lock then recovers to RUN.
- reset asserted mid-MEASURE with mon_tog active → all outputs at reset values immediately, IDLE until the next start.
- mon_tog stuck → meas_cnt = 0, freq_low flag, no release.
